// File: rtl/mersenne_modexp_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mersenne_modexp_core: r = 2^p mod d via square-and-double, Blakley mult.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mersenne_modexp_core #(
  parameter int P_WIDTH = 32,
  parameter int D_WIDTH = 32
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [P_WIDTH-1:0] p,
  input  logic [D_WIDTH-1:0] d,
  output logic               busy,
  output logic               finished,
  output logic               dividesBy,
  output logic [D_WIDTH-1:0] remainder,
  output logic               error
);

  localparam int KW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;
  localparam int CW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SQR  = 2'd1,
    S_DBL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [P_WIDTH-1:0] p_q, p_d;
  logic [D_WIDTH-1:0] d_q, d_d;
  logic [D_WIDTH-1:0] r_q, r_d;
  logic [D_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [KW-1:0]      k_q, k_d;
  logic               busy_q, busy_d;
  logic               fin_q, fin_d;
  logic               div_q, div_d;
  logic               err_q, err_d;
  logic [D_WIDTH-1:0] rem_q, rem_d;

  // Two guard bits keep 2*acc + r below 2^(D_WIDTH+2) even for d = 2^D_WIDTH-1.
  logic [D_WIDTH+1:0] d_ext, r_ext, sqr_a, dbl_a;
  logic [D_WIDTH-1:0] sqr_next, dbl_sel;
  logic               unused_bits;

  assign d_ext = {2'b00, d_q};
  assign r_ext = {2'b00, r_q};

  always_comb begin
    sqr_a = {1'b0, acc_q, 1'b0};
    if (sqr_a >= d_ext) sqr_a = sqr_a - d_ext;
    if (r_q[cnt_q]) sqr_a = sqr_a + r_ext;
    if (sqr_a >= d_ext) sqr_a = sqr_a - d_ext;
    dbl_a = {1'b0, r_q, 1'b0};
    if (dbl_a >= d_ext) dbl_a = dbl_a - d_ext;
  end

  assign sqr_next    = sqr_a[D_WIDTH-1:0];
  assign dbl_sel     = p_q[k_q] ? dbl_a[D_WIDTH-1:0] : r_q;
  assign unused_bits = &{1'b0, sqr_a[D_WIDTH+1:D_WIDTH], dbl_a[D_WIDTH+1:D_WIDTH]};

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    d_d     = d_q;
    r_d     = r_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    busy_d  = busy_q;
    fin_d   = fin_q;
    div_d   = div_q;
    err_d   = err_q;
    rem_d   = rem_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          p_d     = p;
          d_d     = d;
          fin_d   = 1'b0;
          div_d   = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          r_d     = D_WIDTH'(1);
          acc_d   = '0;
          cnt_d   = CW'(D_WIDTH - 1);
          k_d     = KW'(P_WIDTH - 1);
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        // A degenerate divisor spends exactly one cycle here before reporting.
        if (d_q < D_WIDTH'(2)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          fin_d   = 1'b1;
          err_d   = 1'b1;
          div_d   = 1'b0;
          rem_d   = '0;
        end else begin
          acc_d = sqr_next;
          if (cnt_q == '0) begin
            r_d     = sqr_next;
            state_d = S_DBL;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_DBL: begin
        r_d = dbl_sel;
        if (k_q != '0) begin
          k_d     = k_q - KW'(1);
          acc_d   = '0;
          cnt_d   = CW'(D_WIDTH - 1);
          state_d = S_SQR;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          fin_d   = 1'b1;
          rem_d   = dbl_sel;
          div_d   = (dbl_sel == D_WIDTH'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && busy_q) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      fin_d   = 1'b0;
      div_d   = 1'b0;
      err_d   = 1'b0;
      rem_d   = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      div_q   <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      d_q     <= d_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      div_q   <= div_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
    end
  end

  assign busy      = busy_q;
  assign finished  = fin_q;
  assign dividesBy = div_q;
  assign error     = err_q;
  assign remainder = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_mersenne_modexp_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mersenne_modexp_core: directed vectors for the modexp core (8x8).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mersenne_modexp_core;

  localparam int P_WIDTH = 8;
  localparam int D_WIDTH = 8;
  localparam int LAT     = P_WIDTH * (D_WIDTH + 1);

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [P_WIDTH-1:0] p;
  logic [D_WIDTH-1:0] d;
  logic               busy;
  logic               finished;
  logic               divides;
  logic [D_WIDTH-1:0] remainder;
  logic               error;

  int checks   = 0;
  int failures = 0;

  mersenne_modexp_core #(
    .P_WIDTH(P_WIDTH),
    .D_WIDTH(D_WIDTH)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .start    (start),
    .abort    (abort),
    .p        (p),
    .d        (d),
    .busy     (busy),
    .finished (finished),
    .dividesBy(divides),
    .remainder(remainder),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Presents a start request, returns 1 time unit after the accept edge.
  task automatic launch(input logic [P_WIDTH-1:0] pp, input logic [D_WIDTH-1:0] dd);
    p     = pp;
    d     = dd;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (finished) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input logic [P_WIDTH-1:0] pp,
                         input logic [D_WIDTH-1:0] dd, input int exp_rem, input int exp_div);
    int n;
    launch(pp, dd);
    // Scramble the inputs to show they are captured at accept.
    p = ~pp;
    d = dd ^ 8'h5A;
    check({tag, "_busy"}, busy, 1);
    wait_done(n);
    check({tag, "_lat"}, n, LAT);
    check({tag, "_rem"}, remainder, exp_rem);
    check({tag, "_div"}, divides, exp_div);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    p     = '0;
    d     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_fin", finished, 0);
    check("rst_div", divides, 0);
    check("rst_err", error, 0);
    check("rst_rem", remainder, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_vec("v11_23", 8'd11, 8'd23, 1, 1);
    run_vec("v11_13", 8'd11, 8'd13, 7, 0);
    run_vec("v29_233", 8'd29, 8'd233, 1, 1);
    run_vec("v7_127", 8'd7, 8'd127, 1, 1);

    // Degenerate divisors
    launch(8'd3, 8'd1);
    check("d1_busy", busy, 1);
    wait_done(n);
    check("d1_lat", n, 1);
    check("d1_err", error, 1);
    check("d1_div", divides, 0);
    check("d1_rem", remainder, 0);
    launch(8'd5, 8'd0);
    wait_done(n);
    check("d0_lat", n, 1);
    check("d0_err", error, 1);
    launch(8'd11, 8'd23);
    check("clr_err", error, 0);
    check("clr_fin", finished, 0);
    wait_done(n);
    check("after_err_lat", n, LAT);
    check("after_err_rem", remainder, 1);

    // Start while busy is ignored
    launch(8'd11, 8'd13);
    repeat (29) @(posedge clk);
    #1;
    p     = 8'd7;
    d     = 8'd127;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check("ign_lat", n + 30, LAT);
    check("ign_rem", remainder, 7);

    // Abort mid-run
    launch(8'd11, 8'd23);
    repeat (29) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abt_busy", busy, 0);
    check("abt_fin", finished, 0);
    check("abt_rem", remainder, 0);
    run_vec("post_abt", 8'd11, 8'd23, 1, 1);

    // Abort in DONE blocks a simultaneous start
    p     = 8'd11;
    d     = 8'd13;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("abt_done_busy", busy, 0);
    check("abt_done_fin", finished, 1);
    check("abt_done_rem", remainder, 1);

    // Reset mid-run
    launch(8'd11, 8'd13);
    repeat (39) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mrst_busy", busy, 0);
    check("mrst_fin", finished, 0);
    check("mrst_div", divides, 0);
    check("mrst_rem", remainder, 0);
    check("mrst_err", error, 0);

    run_vec("v0_255", 8'd0, 8'd255, 1, 1);
    run_vec("v255_255", 8'd255, 8'd255, 128, 0);

    // Back-to-back: start in the DONE cycle
    launch(8'd11, 8'd13);
    check("b2b_fin", finished, 0);
    check("b2b_busy", busy, 1);
    wait_done(n);
    check("b2b_lat", n, LAT);
    check("b2b_rem", remainder, 7);
    check("b2b_div", divides, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
